mem_port_arbiter: RTL and testbench

Arbitrates one single-port synchronous RAM between the instruction-fetch requester (fetch stage) and the data requester (memory stage LDR/STR). At most one access is issued per cycle. Data accesses have priority. A starvation counter guarantees fetch progress. Per-port stall signals feed the controller's PC-stall logic, and read data is returned on the owning port after a fixed RAM latency.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_tag_pipe.sv | 34 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: owner tags, FSM states, counter widths.
package mem_arb_pkg;

  localparam int unsigned PERF_CNT_W = 16;
  localparam int unsigned STARVE_W   = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_FORCE_IF = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// RD_LAT-deep delay line of read-owner tags; exposes the tag entering the
// return stage (for data capture) and the tag sitting in it (for rvalid).
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_i,
  output owner_t tag_pre_o,
  output owner_t tag_ret_o
);

  owner_t stage_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_ret_o = stage_q[RD_LAT-1];

  if (RD_LAT == 1) begin : g_lat1
    assign tag_pre_o = tag_i;
  end else begin : g_latn
    assign tag_pre_o = stage_q[RD_LAT-2];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch and data requesters, data-priority with
// fetch starvation guard. Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_stall,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_stall,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [PERF_CNT_W-1:0] perf_if_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_conflict_cnt
);

  arb_state_t            state_q, state_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  owner_t                tag_in, tag_pre, tag_ret;
  logic [DATA_W-1:0]     if_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HOLD;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant selection, starvation tracking and RAM mux.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_stall  = 1'b0;
    d_stall   = 1'b0;
    tag_in    = OWN_NONE;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;

    case (state_q)
      S_HOLD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        d_gnt    = d_req;
        if_gnt   = if_req & ~d_req;
        if_stall = if_req & ~if_gnt;
        if (!if_req || if_gnt) begin
          starve_d = '0;
        end else if (d_gnt && (starve_q < STARVE_W'(MAX_STARVE))) begin
          starve_d = starve_q + 1'b1;
        end
        if (if_req && (starve_d == STARVE_W'(MAX_STARVE))) state_d = S_FORCE_IF;
      end
      S_FORCE_IF: begin
        if_gnt   = if_req;
        d_stall  = d_req;
        starve_d = '0;
        state_d  = S_RUN;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase

    if (d_gnt) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      ram_wren  = d_we;
      tag_in    = d_we ? OWN_NONE : OWN_D;
    end else if (if_gnt) begin
      ram_addr  = if_addr;
      tag_in    = OWN_IF;
    end
  end

  mem_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_i     (tag_in),
    .tag_pre_o (tag_pre),
    .tag_ret_o (tag_ret)
  );

  // Capture read data on the edge the owning tag enters the return stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (tag_pre == OWN_IF) if_rdata_q <= ram_rdata;
      if (tag_pre == OWN_D)  d_rdata_q  <= ram_rdata;
    end
  end

  assign if_rvalid = (tag_ret == OWN_IF);
  assign d_rvalid  = (tag_ret == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (if_stall && (stall_cnt_q != '1))         stall_cnt_q    <= stall_cnt_q + 1'b1;
      if (if_req && d_req && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign perf_if_stall_cnt = stall_cnt_q;
  assign perf_conflict_cnt = conflict_cnt_q;
`else
  assign perf_if_stall_cnt = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural RAM, arbitration reference
// and in-order read-return queues per port.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned MAX_STARVE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              if_gnt, if_stall, if_rvalid, d_gnt, d_stall, d_rvalid, ram_wren;
  logic [DATA_W-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       perf_if_stall_cnt, perf_conflict_cnt;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .perf_if_stall_cnt(perf_if_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hA5A5_0000 ^ (32'(a) * 32'h0101_0101) ^ 32'(a);
  endfunction

  // Behavioural synchronous RAM, write-first, one registered read stage.
  logic [DATA_W-1:0] ram_mem [256];
  logic [DATA_W-1:0] rd_q;
  assign ram_rdata = rd_q;
  initial for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    rd_q <= ram_wren ? ram_wdata : ram_mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];

  // Reference: independent memory image plus arbitration rules.
  logic [31:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  bit after_rst = 1'b1;
  bit force_if  = 1'b0;
  int losses    = 0;
  int conf_cnt  = 0;
  int stall_cnt = 0;

  always @(negedge clk) begin
    bit hold, e_ig, e_dg, e_is, e_ds;
    logic [31:0] e_addr;
    hold = 1'b0; e_ig = 1'b0; e_dg = 1'b0;
    if (!rst_n) begin
      after_rst = 1'b1; force_if = 1'b0; losses = 0; conf_cnt = 0; stall_cnt = 0;
    end else begin
      hold = after_rst;
      after_rst = 1'b0;
      if (hold) begin
      end else if (force_if) begin
        e_ig = if_req;
        force_if = 1'b0;
        losses = 0;
      end else begin
        e_dg = d_req;
        e_ig = if_req && !d_req;
        if (!if_req || e_ig) losses = 0;
        else if (e_dg) losses++;
        if (if_req && losses >= int'(MAX_STARVE)) force_if = 1'b1;
      end
    end
    e_is = rst_n && !hold && if_req && !e_ig;
    e_ds = rst_n && !hold && d_req && !e_dg;
    e_addr = e_dg ? 32'(d_addr) : (e_ig ? 32'(if_addr) : 32'd0);
    chk("if_gnt",   32'(if_gnt),   32'(e_ig));
    chk("d_gnt",    32'(d_gnt),    32'(e_dg));
    chk("if_stall", 32'(if_stall), 32'(e_is));
    chk("d_stall",  32'(d_stall),  32'(e_ds));
    chk("ram_wren", 32'(ram_wren), 32'(e_dg && d_we));
    chk("ram_addr", 32'(ram_addr), e_addr);
`ifdef MEM_ARB_PERF_EN
    chk("perf_stall",    32'(perf_if_stall_cnt), 32'(stall_cnt));
    chk("perf_conflict", 32'(perf_conflict_cnt), 32'(conf_cnt));
`else
    chk("perf_stall",    32'(perf_if_stall_cnt), 32'd0);
    chk("perf_conflict", 32'(perf_conflict_cnt), 32'd0);
`endif
    if (rst_n) begin
      if (e_dg && d_we)  ref_mem[d_addr] = d_wdata;
      if (e_dg && !d_we) d_q.push_back('{cyc + int'(RD_LAT), ref_mem[d_addr]});
      if (e_ig)          if_q.push_back('{cyc + int'(RD_LAT), ref_mem[if_addr]});
      if (if_req && d_req && conf_cnt < 65535) conf_cnt++;
      if (e_is && stall_cnt < 65535) stall_cnt++;
    end
  end

  // Monitor: read returns must appear exactly when due, in order, with held data.
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  always @(negedge clk) begin
    bit ev;
    if (!rst_n) begin
      if_q.delete(); d_q.delete();
      exp_if_rdata = '0; exp_d_rdata = '0;
    end
    ev = (if_q.size() > 0) && (if_q[0].due == cyc);
    chk("if_rvalid", 32'(if_rvalid), 32'(ev));
    if (ev) begin exp_if_rdata = if_q[0].data; void'(if_q.pop_front()); end
    chk("if_rdata", if_rdata, exp_if_rdata);
    ev = (d_q.size() > 0) && (d_q[0].due == cyc);
    chk("d_rvalid", 32'(d_rvalid), 32'(ev));
    if (ev) begin exp_d_rdata = d_q[0].data; void'(d_q.pop_front()); end
    chk("d_rdata", d_rdata, exp_d_rdata);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    bit gi, gd;
    rst_n = 1'b0;
    idle_inputs();

    // Fetch pending across reset release: grant only after the hold cycle.
    if_req = 1'b1; if_addr = 8'h10;
    tick(); tick(); rst_n = 1'b1;
    tick(); tick(); if_req = 1'b0;
    repeat (4) tick();

    // Sustained conflict from a fresh reset: starvation guard and perf counts.
    do_reset(); tick();
    if_req = 1'b1; if_addr = 8'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    repeat (10) tick();
    idle_inputs();
    @(negedge clk); #1;
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict_10", 32'(perf_conflict_cnt), 32'd10);
    chk("perf_stall_8",     32'(perf_if_stall_cnt), 32'd8);
`else
    chk("perf_conflict_off", 32'(perf_conflict_cnt), 32'd0);
    chk("perf_stall_off",    32'(perf_if_stall_cnt), 32'd0);
`endif
    tick(); repeat (3) tick();

    // Store then load of the same word in back-to-back cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'hDEAD_BEEF;
    tick(); d_we = 1'b0;
    tick(); d_req = 1'b0;
    repeat (4) tick();

    // Alternating owners in consecutive cycles.
    if_req = 1'b1; if_addr = 8'h01;
    tick(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 8'h03;
    tick(); if_req = 1'b0;
    repeat (4) tick();

    // Randomised traffic; each requester holds its request until granted.
    repeat (600) begin
      @(negedge clk); gi = if_gnt; gd = d_gnt;
      @(posedge clk); #1;
      if (!if_req || gi) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 8'($urandom_range(0, 15));
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = ($urandom_range(0, 1) == 1);
        d_addr  = 8'($urandom_range(0, 15));
        d_wdata = $urandom();
      end
    end
    idle_inputs();
    repeat (6) tick();

    // Reset one cycle after a fetch grant discards the in-flight read.
    if_req = 1'b1; if_addr = 8'h05;
    tick(); if_req = 1'b0; rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk); #1;
    chk("if_rdata_after_rst", if_rdata, 32'd0);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("d_q_drained",  32'(d_q.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
